// File: rtl/alu_rs_if.sv
// Dispatch, ROB broadcast and ALU issue signals of the ALU reservation station.
// The master side is dispatch/ROB/ALU; the slave side is the station itself.
interface alu_rs_if #(
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
);
  logic              flush;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [TAG_W-1:0]  in_dst_tag;
  logic              in_s1_rdy;
  logic [TAG_W-1:0]  in_s1_tag;
  logic [DATA_W-1:0] in_s1_val;
  logic              in_s2_rdy;
  logic [TAG_W-1:0]  in_s2_tag;
  logic [DATA_W-1:0] in_s2_val;

  logic              bc_valid;
  logic [TAG_W-1:0]  bc_tag;
  logic [DATA_W-1:0] bc_data;

  logic              out_valid;
  logic              out_ready;
  logic [OP_W-1:0]   out_op;
  logic [TAG_W-1:0]  out_dst_tag;
  logic [DATA_W-1:0] out_s1;
  logic [DATA_W-1:0] out_s2;

  modport master (
    output flush,
    output in_valid, in_op, in_dst_tag,
    output in_s1_rdy, in_s1_tag, in_s1_val,
    output in_s2_rdy, in_s2_tag, in_s2_val,
    input  in_ready,
    output bc_valid, bc_tag, bc_data,
    input  out_valid, out_op, out_dst_tag, out_s1, out_s2,
    output out_ready
  );

  modport slave (
    input  flush,
    input  in_valid, in_op, in_dst_tag,
    input  in_s1_rdy, in_s1_tag, in_s1_val,
    input  in_s2_rdy, in_s2_tag, in_s2_val,
    output in_ready,
    input  bc_valid, bc_tag, bc_data,
    output out_valid, out_op, out_dst_tag, out_s1, out_s2,
    input  out_ready
  );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: holds micro-ops until both operands arrive (ROB broadcast snoop), issues oldest-ready first.
// Issue 1 cycle after insert/wakeup edge; in_ready drops while full, out_* held until out_ready (oldest-ready may replace).
module alu_rs #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
) (
  input logic     clk_i,
  input logic     rst_i,
  alu_rs_if.slave rs
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  dst_tag;
    logic              s1_rdy;
    logic [TAG_W-1:0]  s1_tag;
    logic [DATA_W-1:0] s1_val;
    logic              s2_rdy;
    logic [TAG_W-1:0]  s2_tag;
    logic [DATA_W-1:0] s2_val;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  // Age rank: number of busy entries older than this one (0 = oldest).
  logic [IDX_W-1:0] age_q [DEPTH];
  logic [IDX_W-1:0] age_d [DEPTH];

  logic [CNT_W-1:0] busy_cnt, cnt_after;
  logic [IDX_W-1:0] free_idx;
  logic             in_rdy;
  logic             sel_vld;
  logic [IDX_W-1:0] sel_idx, sel_age;
  logic             out_vld;
  logic             do_issue, do_insert;
  entry_t           new_ent;

  always_comb begin
    busy_cnt = '0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt = busy_cnt + CNT_W'(busy_q[i]);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
    end
  end

  assign in_rdy      = (busy_cnt < CNT_W'(DEPTH));
  assign rs.in_ready = in_rdy;

  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    sel_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (busy_q[i] && ent_q[i].s1_rdy && ent_q[i].s2_rdy &&
          (!sel_vld || (age_q[i] < sel_age))) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
        sel_age = age_q[i];
      end
    end
  end

  assign out_vld      = sel_vld && !rs.flush;
  assign rs.out_valid = out_vld;

  always_comb begin
    rs.out_op      = '0;
    rs.out_dst_tag = '0;
    rs.out_s1      = '0;
    rs.out_s2      = '0;
    if (out_vld) begin
      rs.out_op      = ent_q[sel_idx].op;
      rs.out_dst_tag = ent_q[sel_idx].dst_tag;
      rs.out_s1      = ent_q[sel_idx].s1_val;
      rs.out_s2      = ent_q[sel_idx].s2_val;
    end
  end

  // Incoming micro-op, with sources satisfied by this cycle's broadcast captured directly.
  always_comb begin
    new_ent.op      = rs.in_op;
    new_ent.dst_tag = rs.in_dst_tag;
    new_ent.s1_rdy  = rs.in_s1_rdy;
    new_ent.s1_tag  = rs.in_s1_tag;
    new_ent.s1_val  = rs.in_s1_val;
    new_ent.s2_rdy  = rs.in_s2_rdy;
    new_ent.s2_tag  = rs.in_s2_tag;
    new_ent.s2_val  = rs.in_s2_val;
    if (rs.bc_valid && !rs.in_s1_rdy && (rs.in_s1_tag == rs.bc_tag)) begin
      new_ent.s1_rdy = 1'b1;
      new_ent.s1_val = rs.bc_data;
    end
    if (rs.bc_valid && !rs.in_s2_rdy && (rs.in_s2_tag == rs.bc_tag)) begin
      new_ent.s2_rdy = 1'b1;
      new_ent.s2_val = rs.bc_data;
    end
  end

  assign do_issue  = out_vld && rs.out_ready;
  assign do_insert = rs.in_valid && in_rdy && !rs.flush;
  assign cnt_after = busy_cnt - CNT_W'(do_issue);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      busy_d[i] = busy_q[i];
      ent_d[i]  = ent_q[i];
      age_d[i]  = age_q[i];

      if (busy_q[i] && rs.bc_valid) begin
        if (!ent_q[i].s1_rdy && (ent_q[i].s1_tag == rs.bc_tag)) begin
          ent_d[i].s1_rdy = 1'b1;
          ent_d[i].s1_val = rs.bc_data;
        end
        if (!ent_q[i].s2_rdy && (ent_q[i].s2_tag == rs.bc_tag)) begin
          ent_d[i].s2_rdy = 1'b1;
          ent_d[i].s2_val = rs.bc_data;
        end
      end

      if (do_issue && busy_q[i]) begin
        if (IDX_W'(i) == sel_idx) begin
          busy_d[i] = 1'b0;
        end else if (age_q[i] > sel_age) begin
          age_d[i] = age_q[i] - 1'b1;
        end
      end

      // free_idx is never the issuing entry: it is chosen among non-busy slots.
      if (do_insert && (IDX_W'(i) == free_idx)) begin
        busy_d[i] = 1'b1;
        ent_d[i]  = new_ent;
        age_d[i]  = IDX_W'(cnt_after);
      end

      if (rs.flush) begin
        busy_d[i] = 1'b0;
        age_d[i]  = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= age_d[i];
        ent_q[i] <= ent_d[i];
      end
    end
  end

endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station for the ALU issue port: buffers decoded ALU micro-ops between IDEX and EX until both source operands are available, then issues them oldest-first. It is the receiving end of the ROB result broadcast: it snoops every broadcast tag/value pair and wakes up entries waiting on that ROB tag. Sits between the decode-side dispatch (which supplies ROB destination tags and operand tags/values) and the ALU in EX.

## Interface
- DEPTH, 4, number of entries (power of two, ≥2)
- TAG_W, 3, ROB tag width
- DATA_W, 32, operand/result width
- OP_W, 5, ALU opcode width

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  mispredict/jump flush; drop every entry
- in_valid  in  1  dispatch offers a micro-op
- in_ready  out  1  station can accept (registered-state derived)
- in_op  in  OP_W  ALU opcode
- in_dst_tag  in  TAG_W  ROB entry receiving the result
- in_s1_rdy / in_s2_rdy  in  1 each  operand value already valid
- in_s1_tag / in_s2_tag  in  TAG_W each  producing ROB tag when not ready
- in_s1_val / in_s2_val  in  DATA_W each  operand value when ready
- bc_valid  in  1  ROB broadcast valid
- bc_tag  in  TAG_W  broadcast ROB tag
- bc_data  in  DATA_W  broadcast result
- out_valid  out  1  a fully-ready entry is presented
- out_ready  in  1  ALU accepts this cycle
- out_op  out  OP_W  issued opcode
- out_dst_tag  out  TAG_W  issued destination tag
- out_s1 / out_s2  out  DATA_W each  issued operand values

## Operation
- Entry state: busy, op, dst_tag, per-source {rdy, tag, val}, age rank.
- Insert: in_valid && in_ready (and !flush) writes the lowest-index free entry; new entry is youngest.
- in_ready = (busy count < DEPTH), computed from current registers only; an issue in the same cycle does not raise in_ready.
- Wakeup: when bc_valid, every busy entry source with rdy=0 and tag==bc_tag captures bc_data and sets rdy=1 at the edge. Both sources of one entry may wake on the same broadcast.
- Insert bypass: an incoming source with in_sN_rdy=0 and in_sN_tag==bc_tag while bc_valid is written already ready with bc_data.
- Select: among busy entries with both sources ready, the oldest is presented; out_valid=1 iff one exists. Outputs are muxed from registered entry state (no combinational path from bc_* or in_* to out_*).
- Issue: out_valid && out_ready frees the selected entry at the edge; remaining entries keep relative age.
- Simultaneous insert + issue + wakeup in one cycle: all three take effect; insert never overwrites the entry being freed.
- Flush: at the edge clears all busy bits; overrides insert, issue and wakeup of that cycle. out_valid is forced 0 while flush=1, so no handshake completes in a flush cycle.
- Reset: all busy=0, age state cleared. Outputs after reset: in_ready=1, out_valid=0, out_op=0, out_dst_tag=0, out_s1=0, out_s2=0 (outputs are zero whenever out_valid=0).

## Timing
- Insert with both sources ready: out_valid earliest in the cycle after the insert edge (1-cycle latency).
- Wakeup: broadcast at edge N -> entry eligible, out_valid in cycle N+1.
- Freed slot reusable: in_ready rises the cycle after the issue edge.
- Full: in_ready=0 while DEPTH entries busy; in_valid held by dispatch, no drop.
- A broadcast for a tag no entry waits on has no effect; a repeated broadcast of a tag already captured has no effect.
- out_* stable while out_valid=1 and out_ready=0 unless an older entry becomes ready (then oldest-ready is presented; no hold requirement on the ALU side).

## Test plan
- Reset, then insert op=3 dst=5 s1=10 s2=20 both ready, out_ready=1 -> cycle after insert out_valid=1, out_op=3, out_dst_tag=5, out_s1=10, out_s2=20; next cycle out_valid=0.
- Insert dst=1 waiting s1 on tag 2; broadcast tag 2 data 0xDEAD two cycles later -> out_valid one cycle after broadcast, out_s1=0xDEAD.
- Insert waiting on tag 4 in the same cycle bc_valid tag 4 data 7 -> entry ready, issues next cycle with out_s1=7.
- Fill DEPTH=4 entries all waiting, in_valid held -> in_ready=0; broadcast wakes entries 2 and 0 (insert order 0..3) same cycle -> entry 0 (oldest) issues first, then 2; in_ready=1 the cycle after first issue.
- With 3 busy entries, assert flush together with in_valid and bc_valid -> next cycle busy count 0, in_ready=1, out_valid=0, no issue handshake in flush cycle.
- Assert rst mid-operation with 2 ready entries and out_ready=0 -> next cycle out_valid=0, all outputs 0, in_ready=1.
